md_issue_queue: RTL and testbench
=================================

MD_ISSUE_QUEUE -- requirements
Module: md_issue_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting queue entry count (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port op_valid  input  1  E-stage holds an HI/LO-writing op (mult/multu/div/divu/mthi/mtlo).
REQ-005 The block SHALL have port op  input  3  op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo.
REQ-006 The block SHALL have ports a, b  input  32 each  operand values from E stage, already forwarded.
REQ-007 The block SHALL have port op_ready  output  1  queue accepts a push this cycle.
REQ-008 The block SHALL have port mf_req  input  1  E stage holds mfhi or mflo.
REQ-009 The block SHALL have port md_busy  input  1  busy flag from the downstream multiply/divide unit.
REQ-010 The block SHALL have ports md_start  output  1, md_op  output  3, md_a/md_b  output  32  drive the downstream unit.
REQ-011 The block SHALL have port stall_md  output  1  freeze F/D/E stages.

Function
REQ-012 The block SHALL push {op,a,b} when op_valid && op_ready && op<=5; op codes 6/7 SHALL be dropped silently.
REQ-013 The block SHALL drive op_ready = !full; a push SHALL NOT be accepted when full, even if a pop occurs in the same cycle.
REQ-014 The block SHALL provide no bypass: an op pushed at edge N is first issuable in cycle N+1 (minimum push-to-md_start latency 1 cycle).
REQ-015 The block SHALL issue (pop head) in any cycle with queue non-empty && !md_busy.
REQ-016 In an issue cycle, md_op/md_a/md_b SHALL equal the head entry; md_start SHALL be 1 for ops 0-3 and 0 for ops 4-5.
REQ-017 In a non-issue cycle, md_op SHALL be 7 (idle) and md_start 0, so the downstream unit never sees a spurious mthi/mtlo; md_a/md_b SHALL be 0.
REQ-018 Issue SHALL be strictly in push order, one op per cycle; after a mult/div issue, md_busy rises at the next edge and blocks further issue.
REQ-019 Back-to-back mthi/mtlo SHALL issue on consecutive cycles, since md_busy stays 0.
REQ-020 Simultaneous push and pop with queue non-full SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-021 stall_md SHALL be (mf_req && (count!=0 || md_busy)) || (op_valid && op<=5 && full); it is combinational, with no registered delay.
REQ-022 A pushing E-stage op while stall_md is asserted due to full SHALL NOT be enqueued twice; the push occurs only in the cycle op_ready=1.
REQ-023 Count SHALL saturate-check: no push beyond DEPTH, no pop below 0.

Reset
REQ-024 On reset the block SHALL clear read/write pointers and count to 0; entry storage need not be cleared.
REQ-025 During and immediately after reset, outputs SHALL be: op_ready=1, md_start=0, md_op=7, md_a=md_b=0, stall_md=0 unless mf_req.
REQ-026 Reset mid-operation SHALL discard all queued ops; a downstream op already issued is not recalled.

Structure
REQ-027 Op codes 0-5 and idle code 7 SHALL be defined once in the shared define.v header and used by both this block and the multiply/divide unit.
REQ-028 Storage SHALL be a sub-module sync_fifo (parameters WIDTH=67, DEPTH; ports clk, reset, push, pop, din, dout, full, empty, count).
REQ-029 Issue and stall logic SHALL reside in md_issue_queue itself.

Verification
REQ-030 mult a=3,b=-2, md_busy low -> md_start=1, md_op=0, md_a=3, md_b=0xFFFFFFFE exactly one cycle after push.
REQ-031 Push mult, div, mthi back-to-back, with md_busy modelled as 5/10-cycle windows -> issue order 0,2,4; div issues first idle cycle after mult's busy falls.
REQ-032 DEPTH=4: five pushes with md_busy held 1 -> op_ready=0 after 4th; stall_md=1 with 5th pending; 5th enqueued once busy drops and a pop occurs.
REQ-033 mf_req with queue holding one mtlo -> stall_md=1 until issue; cleared the cycle after (count 0, md_busy 0).
REQ-034 Reset asserted with 3 queued ops -> next cycle count=0, md_op=7, md_start=0, op_ready=1.
REQ-035 op=6 with op_valid -> no push, count unchanged, no md_start.

Source files
------------

// File: rtl/md_issue_queue_pkg.sv
// Shared HI/LO op encodings and the queue entry layout.
// Used by the issue queue and by the downstream multiply/divide unit.
package md_issue_queue_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_IDLE  = 3'd7
    } md_op_e;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = 3 + 2 * DATA_W;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } md_entry_t;

    // Codes 6 and 7 never enter the queue.
    function automatic logic is_md_op(input logic [2:0] code);
        return code <= 3'(MD_MTLO);
    endfunction

    // Only mult/div variants occupy the downstream unit.
    function automatic logic starts_unit(input logic [2:0] code);
        return code <= 3'(MD_DIVU);
    endfunction

endpackage

// File: rtl/md_issue_queue_sync_fifo.sv
// Synchronous FIFO: a push is refused when full, even alongside a pop.
// Entry storage is not reset; only pointers and count are.
module sync_fifo #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two DEPTH lets the pointers wrap by plain overflow.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/md_issue_queue.sv
// Queues HI/LO-writing ops from E stage and issues them in order to the
// multiply/divide unit; also produces the front-end stall for full/mfhi/mflo.
module md_issue_queue
    import md_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        op_ready,
    input  logic        mf_req,
    input  logic        md_busy,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall_md
);

    localparam int CW = $clog2(DEPTH + 1);

    md_entry_t     din;
    md_entry_t     head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          push;
    logic          issue;
    logic          op_ok;

    assign op_ok = op_valid && is_md_op(op);
    assign din   = '{op: op, a: a, b: b};

    // Reset masks full so the front end sees a ready, non-stalling queue.
    assign op_ready = reset || !full;
    assign push     = op_ok && !full && !reset;
    assign issue    = !empty && !md_busy && !reset;
    assign stall_md = (mf_req && (count != '0 || md_busy)) || (op_ok && full && !reset);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (issue),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        md_op    = 3'(MD_IDLE);
        md_a     = '0;
        md_b     = '0;
        md_start = 1'b0;
        if (issue) begin
            md_op    = head.op;
            md_a     = head.a;
            md_b     = head.b;
            md_start = starts_unit(head.op);
        end
    end

endmodule

// File: tb/tb_md_issue_queue.sv
// Directed bench for md_issue_queue (DEPTH=4) with a small md_busy model.
module tb_md_issue_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        op_ready;
    logic        mf_req;
    logic        md_busy;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall_md;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int c0;
    int busy_cnt = 0;
    logic force_busy = 1'b0;

    logic [2:0]  iss_op  [$];
    logic [31:0] iss_a   [$];
    int          iss_cyc [$];

    always #5 clk = ~clk;

    md_issue_queue #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .a        (a),
        .b        (b),
        .op_ready (op_ready),
        .mf_req   (mf_req),
        .md_busy  (md_busy),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .stall_md (stall_md)
    );

    // Downstream unit: busy 5 cycles after mult, 10 after div, from the next edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (md_start)
            busy_cnt <= (md_op == 3'd2 || md_op == 3'd3) ? 10 : 5;
        else if (busy_cnt != 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign md_busy = force_busy | (busy_cnt != 0);

    always @(negedge clk) begin
        if (md_op != 3'd7) begin
            iss_op.push_back(md_op);
            iss_a.push_back(md_a);
            iss_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        iss_op.delete();
        iss_a.delete();
        iss_cyc.delete();
    endtask

    function automatic logic [2:0] log_op(input int i);
        return (i < iss_op.size()) ? iss_op[i] : 3'd7;
    endfunction

    function automatic logic [31:0] log_a(input int i);
        return (i < iss_a.size()) ? iss_a[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int log_rel(input int i);
        return (i < iss_cyc.size()) ? iss_cyc[i] - c0 : -1;
    endfunction

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = '0; a = '0; b = '0; mf_req = 1'b0;
        tick();
        tick();
        #1;
        check("rst_during_ready", op_ready, 1);
        check("rst_during_op", md_op, 7);
        check("rst_during_stall", stall_md, 0);
        reset = 1'b0;
        tick();
        #1;
        check("rst_count", dut.u_fifo.count, 0);
        check("rst_start", md_start, 0);
        check("rst_md_a", md_a, 0);
        check("rst_md_b", md_b, 0);

        // mult 3 * -2: visible one cycle after the push, never the same cycle
        op_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'hFFFF_FFFE;
        #1;
        check("mult_no_bypass", md_start, 0);
        check("mult_ready", op_ready, 1);
        tick();
        op_valid = 1'b0;
        #1;
        check("mult_start", md_start, 1);
        check("mult_op", md_op, 0);
        check("mult_a", md_a, 3);
        check("mult_b", md_b, 32'hFFFF_FFFE);
        tick();
        #1;
        check("mult_after_op", md_op, 7);
        check("mult_after_count", dut.u_fifo.count, 0);
        repeat (8) tick();

        // mult, div, mthi back-to-back against the busy windows
        clear_log();
        c0 = cyc;
        op_valid = 1'b1; op = 3'd0; a = 32'd10; b = 32'd1;
        tick();
        op = 3'd2; a = 32'd20;
        tick();
        op = 3'd4; a = 32'd30;
        tick();
        op_valid = 1'b0;
        repeat (20) tick();
        check("ord_n", iss_op.size(), 3);
        check("ord_op0", log_op(0), 0);
        check("ord_cyc0", log_rel(0), 1);
        check("ord_op1", log_op(1), 2);
        check("ord_cyc1", log_rel(1), 7);
        check("ord_op2", log_op(2), 4);
        check("ord_cyc2", log_rel(2), 18);

        // mf_req waits on a queued mtlo until it issues
        force_busy = 1'b1;
        op_valid = 1'b1; op = 3'd5; a = 32'd7;
        tick();
        op_valid = 1'b0; mf_req = 1'b1;
        #1;
        check("mf_stall_q", stall_md, 1);
        check("mf_held_op", md_op, 7);
        tick();
        force_busy = 1'b0;
        #1;
        check("mf_issue_op", md_op, 5);
        check("mf_issue_start", md_start, 0);
        check("mf_issue_stall", stall_md, 1);
        tick();
        #1;
        check("mf_clear_stall", stall_md, 0);
        mf_req = 1'b0;

        // mthi then mtlo issue on consecutive cycles
        clear_log();
        c0 = cyc;
        op_valid = 1'b1; op = 3'd4; a = 32'd40;
        tick();
        op = 3'd5; a = 32'd50;
        tick();
        op_valid = 1'b0;
        repeat (3) tick();
        check("mt_n", iss_op.size(), 2);
        check("mt_op0", log_op(0), 4);
        check("mt_cyc0", log_rel(0), 1);
        check("mt_op1", log_op(1), 5);
        check("mt_cyc1", log_rel(1), 2);

        // fill DEPTH=4 under busy, fifth op stalls then enqueues exactly once
        force_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            op_valid = 1'b1; op = 3'd0; a = 32'(i); b = 32'd0;
            tick();
        end
        a = 32'd5;
        #1;
        check("full_ready", op_ready, 0);
        check("full_stall", stall_md, 1);
        check("full_count", dut.u_fifo.count, 4);
        tick();
        #1;
        check("full_hold_count", dut.u_fifo.count, 4);
        clear_log();
        force_busy = 1'b0;
        #1;
        check("full_pop_start", md_start, 1);
        check("full_pop_a", md_a, 1);
        check("full_pop_ready", op_ready, 0);
        check("full_pop_stall", stall_md, 1);
        tick();
        #1;
        check("full_after_ready", op_ready, 1);
        check("full_after_stall", stall_md, 0);
        check("full_after_count", dut.u_fifo.count, 3);
        tick();
        op_valid = 1'b0;
        #1;
        check("full_fifth_count", dut.u_fifo.count, 4);
        repeat (40) tick();
        check("full_n", iss_a.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("full_a%0d", i), log_a(i), 32'(i + 1));

        // reset discards queued ops
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_valid = 1'b1; op = 3'd1; a = 32'(i);
            tick();
        end
        op_valid = 1'b0;
        #1;
        check("rq_count", dut.u_fifo.count, 3);
        reset = 1'b1;
        #1;
        check("rq_during_op", md_op, 7);
        check("rq_during_ready", op_ready, 1);
        tick();
        reset = 1'b0;
        force_busy = 1'b0;
        #1;
        check("rq_count0", dut.u_fifo.count, 0);
        check("rq_op", md_op, 7);
        check("rq_start", md_start, 0);
        check("rq_ready", op_ready, 1);

        // illegal op codes are dropped
        clear_log();
        op_valid = 1'b1; op = 3'd6; a = 32'd99;
        tick();
        op = 3'd7;
        tick();
        op_valid = 1'b0;
        #1;
        check("bad_count", dut.u_fifo.count, 0);
        repeat (2) tick();
        check("bad_no_issue", iss_op.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
